// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: walks one-hot column drive, debounces a single key
// press/release per scan FSM, and queues row*COLS+col codes in a small FIFO.
module keypad_scan_fifo #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned SCAN_DIV   = 16,
  parameter int unsigned DEBOUNCE   = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CW        = $clog2(ROWS * COLS),
  localparam int unsigned NW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_drive,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [NW-1:0]   fifo_count,
  output logic            key_held,
  output logic            overflow,
  input  logic            clear_overflow
);

  localparam int unsigned DW   = $clog2(SCAN_DIV);
  localparam int unsigned COLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROWW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SW   = $clog2(DEBOUNCE + 1);
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CAND, HELD} state_e;

  logic [DW-1:0]   div_q, div_d;
  logic [COLW-1:0] col_q, col_d;
  logic [COLS-1:0] col_drive_q, col_drive_d;
  state_e          state_q, state_d;
  logic [COLW-1:0] cand_col_q, cand_col_d;
  logic [ROWW-1:0] cand_row_q, cand_row_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [NW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  logic            run_c, sample_c, push_c, pop_c, full_c, do_push_c, drop_c;
  logic [ROWW-1:0] low_row_c;
  logic [SW-1:0]   cnt_inc_c;
  logic [CW-1:0]   push_code_c;

  // Column walk; the first enabled cycle only starts the drive so column 0 gets a full period.
  always_comb begin
    run_c       = |col_drive_q;
    sample_c    = enable && run_c && (div_q == DW'(SCAN_DIV - 1));
    div_d       = '0;
    col_d       = '0;
    if (enable && run_c) begin
      if (div_q == DW'(SCAN_DIV - 1)) begin
        col_d = (col_q == COLW'(COLS - 1)) ? '0 : col_q + COLW'(1);
      end else begin
        div_d = div_q + DW'(1);
        col_d = col_q;
      end
    end
    col_drive_d = enable ? (COLS'(1) << col_d) : '0;
  end

  always_comb begin
    low_row_c = '0;
    for (int r = int'(ROWS) - 1; r >= 0; r--) begin
      if (row_in[r]) low_row_c = ROWW'(r);
    end
  end

  // Scan FSM; cnt counts stable press samples in CAND and release samples in HELD.
  always_comb begin
    state_d    = state_q;
    cand_col_d = cand_col_q;
    cand_row_d = cand_row_q;
    cnt_d      = cnt_q;
    push_c     = 1'b0;
    cnt_inc_c  = cnt_q + SW'(1);
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (sample_c) begin
      unique case (state_q)
        IDLE: begin
          if (|row_in) begin
            cand_col_d = col_q;
            cand_row_d = low_row_c;
            cnt_d      = SW'(1);
            if (DEBOUNCE == 1) begin
              push_c  = 1'b1;
              state_d = HELD;
              cnt_d   = '0;
            end else begin
              state_d = CAND;
            end
          end
        end
        CAND: begin
          if (col_q == cand_col_q) begin
            if (row_in[cand_row_q]) begin
              cnt_d = cnt_inc_c;
              if (cnt_inc_c == SW'(DEBOUNCE)) begin
                push_c  = 1'b1;
                state_d = HELD;
                cnt_d   = '0;
              end
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
        HELD: begin
          if (col_q == cand_col_q) begin
            if (!row_in[cand_row_q]) begin
              cnt_d = cnt_inc_c;
              if (cnt_inc_c == SW'(DEBOUNCE)) begin
                state_d = IDLE;
                cnt_d   = '0;
              end
            end else begin
              cnt_d = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    push_code_c = CW'(32'(cand_row_d) * COLS + 32'(cand_col_d));
  end

  // FIFO bookkeeping; a pop in the same cycle frees the slot for a push into a full queue.
  always_comb begin
    pop_c     = (count_q != '0) && key_ready;
    full_c    = (count_q == NW'(FIFO_DEPTH));
    do_push_c = push_c && (!full_c || pop_c);
    drop_c    = push_c && full_c && !pop_c;
    rd_d      = pop_c ? rd_q + PW'(1) : rd_q;
    wr_d      = do_push_c ? wr_q + PW'(1) : wr_q;
    count_d   = count_q + NW'(do_push_c) - NW'(pop_c);
    ovf_d     = drop_c ? 1'b1 : (clear_overflow ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      col_q       <= '0;
      col_drive_q <= '0;
      state_q     <= IDLE;
      cand_col_q  <= '0;
      cand_row_q  <= '0;
      cnt_q       <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      div_q       <= div_d;
      col_q       <= col_d;
      col_drive_q <= col_drive_d;
      state_q     <= state_d;
      cand_col_q  <= cand_col_d;
      cand_row_q  <= cand_row_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      if (do_push_c) mem_q[wr_q] <= push_code_c;
    end
  end

  assign col_drive  = col_drive_q;
  assign key_code   = mem_q[rd_q];
  assign key_valid  = (count_q != '0);
  assign fifo_count = count_q;
  assign key_held   = (state_q == HELD);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Testbench for keypad_scan_fifo: a keypad model answers the column drive and
// a time-based scan/debounce/queue reference predicts every output each cycle.
module tb_keypad_scan_fifo;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SD   = 16;
  localparam int DB   = 3;
  localparam int FD   = 4;
  localparam int CW   = $clog2(ROWS * COLS);
  localparam int NW   = $clog2(FD + 1);
  localparam int SCAN = COLS * SD;

  localparam int P_IDLE = 0;
  localparam int P_CAND = 1;
  localparam int P_HELD = 2;

  logic            clk;
  logic            reset;
  logic            enable;
  logic [ROWS-1:0] row_in;
  logic [COLS-1:0] col_drive;
  logic [CW-1:0]   key_code;
  logic            key_valid;
  logic            key_ready;
  logic [NW-1:0]   fifo_count;
  logic            key_held;
  logic            overflow;
  logic            clear_overflow;

  logic [ROWS*COLS-1:0] keys;
  logic [ROWS*COLS-1:0] rnd_mask;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int m_run, m_t, m_phase, m_ccol, m_crow, m_n, m_ovf;
  int q[$];

  keypad_scan_fifo #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .row_in(row_in),
    .col_drive(col_drive), .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready), .fifo_count(fifo_count), .key_held(key_held),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to its column drive.
  always_comb begin
    row_in = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && col_drive[c]) row_in[r] = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_phase = P_IDLE; m_n = 0; m_run = 0; m_t = 0;
    m_ccol = 0; m_crow = 0;
  endtask

  function automatic logic [ROWS-1:0] model_rows(input int col);
    logic [ROWS-1:0] r;
    for (int i = 0; i < ROWS; i++) r[i] = keys[i*COLS+col];
    return r;
  endfunction

  task automatic check_all();
    logic [31:0] exp_cd;
    exp_cd = (m_run != 0) ? (32'd1 << ((m_t / SD) % COLS)) : 32'd0;
    chk("col_drive", 32'(col_drive), exp_cd);
    chk("key_valid", 32'(key_valid), 32'(q.size() != 0));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    if (q.size() != 0) chk("key_code", 32'(key_code), 32'(q[0]));
    chk("key_held", 32'(key_held), 32'(m_phase == P_HELD));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Advance one clock: predict from the inputs of this cycle, then compare.
  task automatic step();
    int col, lowr, code;
    bit samp, push, drop;
    logic [ROWS-1:0] rows;
    col  = (m_t / SD) % COLS;
    samp = enable && !reset && (m_run != 0) && (m_t % SD == SD - 1);
    rows = model_rows(col);
    push = 0; drop = 0; code = 0;
    if (reset) begin
      model_reset();
    end else begin
      if (!enable) begin
        m_phase = P_IDLE; m_n = 0;
      end else if (samp) begin
        if (m_phase == P_IDLE) begin
          if (rows != 0) begin
            lowr = 0;
            while (!rows[lowr]) lowr++;
            m_ccol = col; m_crow = lowr; m_n = 1;
            if (DB == 1) begin push = 1; m_phase = P_HELD; m_n = 0; end
            else m_phase = P_CAND;
          end
        end else if (col == m_ccol) begin
          if (m_phase == P_CAND) begin
            if (rows[m_crow]) begin
              m_n++;
              if (m_n == DB) begin push = 1; m_phase = P_HELD; m_n = 0; end
            end else begin
              m_phase = P_IDLE; m_n = 0;
            end
          end else begin
            if (!rows[m_crow]) begin
              m_n++;
              if (m_n == DB) begin m_phase = P_IDLE; m_n = 0; end
            end else m_n = 0;
          end
        end
      end
      code = m_crow * COLS + m_ccol;
      if (q.size() != 0 && key_ready) void'(q.pop_front());
      if (push) begin
        if (q.size() < FD) q.push_back(code);
        else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (clear_overflow) m_ovf = 0;
      if (!enable) begin m_run = 0; m_t = 0; end
      else if (m_run == 0) begin m_run = 1; m_t = 0; end
      else m_t = (m_t + 1) % SCAN;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Stop just before the edge that samples column c.
  task automatic goto_sample(input int c);
    int k;
    k = 0;
    while (!((m_run != 0) && enable && (m_t % SD == SD - 1) && ((m_t / SD) % COLS == c))
           && k < 2 * SCAN) begin
      step();
      k++;
    end
    if (k >= 2 * SCAN) begin
      n_assert++;
      n_fail++;
      $error("FAIL goto_sample timeout observed=%0d expected<%0d", k, 2 * SCAN);
    end
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("areset_col_drive", 32'(col_drive), 32'd0);
    chk("areset_key_valid", 32'(key_valid), 32'd0);
    chk("areset_fifo_count", 32'(fifo_count), 32'd0);
    chk("areset_overflow", 32'(overflow), 32'd0);
    chk("areset_key_held", 32'(key_held), 32'd0);
    chk("areset_key_code", 32'(key_code), 32'd0);
    model_reset();
    steps(2);
    reset = 1'b0;
  endtask

  task automatic press_release(input int code);
    keys[code] = 1'b1;
    steps(4 * SCAN);
    keys[code] = 1'b0;
    steps(4 * SCAN);
  endtask

  task automatic drain();
    key_ready = 1'b1;
    steps(FD + 1);
    key_ready = 1'b0;
  endtask

  task automatic rsteps(input int n);
    for (int i = 0; i < n; i++) begin
      key_ready      = ($urandom_range(0, 2) == 0);
      clear_overflow = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) keys = keys ^ rnd_mask;
      step();
    end
    key_ready = 1'b0;
    clear_overflow = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_codes[4];
    reset = 1'b1; enable = 1'b1; key_ready = 1'b0; clear_overflow = 1'b0;
    keys = '0; rnd_mask = '0;
    model_reset();
    steps(3);
    chk("rst_col_drive", 32'(col_drive), 32'd0);
    chk("rst_key_code", 32'(key_code), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);

    // column walk after reset release
    reset = 1'b0;
    step();
    chk("walk0", 32'(col_drive), 32'b0001);
    steps(SD); chk("walk1", 32'(col_drive), 32'b0010);
    steps(SD); chk("walk2", 32'(col_drive), 32'b0100);
    steps(SD); chk("walk3", 32'(col_drive), 32'b1000);
    steps(SD); chk("walk4", 32'(col_drive), 32'b0001);
    steps(7);
    async_reset();
    steps(SD + 3);

    // clean press of row1/col2
    goto_sample(2);
    keys[6] = 1'b1;
    steps(3 * SCAN);
    chk("clean_code", 32'(key_code), 32'd6);
    chk("clean_valid", 32'(key_valid), 32'd1);
    chk("clean_held", 32'(key_held), 32'd1);
    keys = '0;
    steps(4 * SCAN);
    chk("clean_released", 32'(key_held), 32'd0);
    chk("clean_one_push", 32'(fifo_count), 32'd1);
    drain();

    // bounce: one high sample then low
    goto_sample(2);
    keys[6] = 1'b1; step();
    keys = '0; goto_sample(2); step();
    steps(2 * SCAN);
    chk("bounce_count", 32'(fifo_count), 32'd0);

    // glitch during HELD
    keys[6] = 1'b1; steps(4 * SCAN);
    goto_sample(2); keys = '0; step();
    keys[6] = 1'b1; goto_sample(2); step();
    steps(4 * SCAN);
    chk("glitch_held", 32'(key_held), 32'd1);
    keys = '0; steps(4 * SCAN); drain();

    // priority: rows 0 and 3 on col1, then a rollover attempt
    keys[1] = 1'b1; keys[13] = 1'b1;
    steps(4 * SCAN);
    chk("prio_code", 32'(key_code), 32'd1);
    keys[10] = 1'b1;
    steps(4 * SCAN);
    chk("rollover_count", 32'(fifo_count), 32'd1);
    keys = '0; steps(4 * SCAN); drain();

    // overflow with five presses
    press_release(0); press_release(5); press_release(10);
    press_release(15); press_release(3);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    goto_sample(0); keys[12] = 1'b1; step();
    goto_sample(0); step();
    goto_sample(0); clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    keys = '0; steps(4 * SCAN);
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // full FIFO with pop and push in the same cycle
    goto_sample(1); keys[9] = 1'b1; step();
    goto_sample(1); step();
    goto_sample(1); key_ready = 1'b1; step(); key_ready = 1'b0;
    chk("full_pp_count", 32'(fifo_count), 32'd4);
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    keys = '0; steps(4 * SCAN);
    exp_codes = '{5, 10, 15, 9};
    for (int i = 0; i < 4; i++) begin
      chk("pop_order", 32'(key_code), 32'(exp_codes[i]));
      key_ready = 1'b1; step(); key_ready = 1'b0;
    end
    chk("pop_empty", 32'(fifo_count), 32'd0);

    // enable dropped mid-CAND
    goto_sample(3); keys[7] = 1'b1; step();
    steps(5); enable = 1'b0; step();
    chk("dis_col_drive", 32'(col_drive), 32'd0);
    steps(20); keys = '0; enable = 1'b1;
    steps(4 * SCAN);
    chk("dis_no_push", 32'(fifo_count), 32'd0);

    // mid-press reset re-detects the held key
    keys[6] = 1'b1; steps(4 * SCAN);
    async_reset();
    steps(4 * SCAN);
    chk("redetect_count", 32'(fifo_count), 32'd1);
    chk("redetect_held", 32'(key_held), 32'd1);
    keys = '0; steps(4 * SCAN); drain();

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      keys = '0;
      keys[$urandom_range(0, ROWS * COLS - 1)] = 1'b1;
      if ($urandom_range(0, 4) == 0) keys[$urandom_range(0, ROWS * COLS - 1)] = 1'b1;
      rnd_mask = keys;
      rsteps($urandom_range(10, 300));
      if ($urandom_range(0, 7) == 0) begin
        enable = 1'b0;
        rsteps($urandom_range(1, 40));
        enable = 1'b1;
      end
      keys = '0;
      rsteps($urandom_range(10, 300));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
